multicycle_ctrl: RTL

//  Multi-cycle sequencer for the MIPS-subset datapath. It steps each instruction

---
 rtl/multicycle_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath. It steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, stalls on a req/ready memory handshake,
// counts retired instructions, and halts on an illegal opcode or a memory timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_load,
  output logic [1:0]       pc_src,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrc,
  output logic [3:0]       aluctl,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_LW   = 6'b000011;
  localparam logic [5:0] OP_SW   = 6'b001011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b111000;
  localparam logic [5:0] OP_ADD  = 6'b100010;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b010010;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state;
  logic [TW-1:0] tcnt;

  logic is_lw_c, is_sw_c, is_addi_c, is_subi_c, is_add_c, is_beq_c, is_bne_c, is_j_c;
  logic legal_c, alusrc_c, timeout_c, retire_c;
  logic [3:0] alu_c;
  logic funct_unused;

  // Only the low nibble of funct selects the R-type ALU operation.
  assign funct_unused = ^funct[5:4];

  // Opcode decode and ALU operation select.
  always_comb begin
    is_lw_c   = (opcode == OP_LW);
    is_sw_c   = (opcode == OP_SW);
    is_addi_c = (opcode == OP_ADDI);
    is_subi_c = (opcode == OP_SUBI);
    is_add_c  = (opcode == OP_ADD);
    is_beq_c  = (opcode == OP_BEQ);
    is_bne_c  = (opcode == OP_BNE);
    is_j_c    = (opcode == OP_J);
    legal_c   = is_lw_c | is_sw_c | is_addi_c | is_subi_c |
                is_add_c | is_beq_c | is_bne_c | is_j_c;
    alusrc_c  = is_lw_c | is_sw_c | is_addi_c | is_subi_c;
    alu_c     = 4'd0;
    if (is_lw_c | is_sw_c | is_addi_c)       alu_c = 4'd2;
    else if (is_subi_c | is_beq_c | is_bne_c) alu_c = 4'd6;
    else if (is_add_c)                        alu_c = funct[3:0];
  end

  // Timeout fires on the last permitted wait cycle; a ready that cycle still wins.
  assign timeout_c = !mem_ready && (tcnt == TW'(MEM_TIMEOUT - 1));

  // Cycles in which an instruction completes.
  assign retire_c = ((state == S_DECODE) && is_j_c) ||
                    ((state == S_EXEC) && (is_beq_c || is_bne_c)) ||
                    ((state == S_MEM) && is_sw_c && mem_ready) ||
                    (state == S_WB);

  // Sequencer state, wait counter, retire counter and sticky error status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RST;
      tcnt     <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      err_code <= 2'd0;
    end else begin
      if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;

      if (retire_c)
        retired <= retired + CNT_W'(1);

      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
          else if (timeout_c) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            err_code <= 2'd2;
          end
        end
        S_DECODE: begin
          if (!legal_c) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            err_code <= 2'd1;
          end else if (is_j_c) state <= S_FETCH;
          else                 state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_beq_c || is_bne_c)    state <= S_FETCH;
          else if (is_lw_c || is_sw_c) state <= S_MEM;
          else                         state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) state <= is_sw_c ? S_FETCH : S_WB;
          else if (timeout_c) begin
            state    <= S_HALT;
            halted   <= 1'b1;
            err_code <= 2'd2;
          end
        end
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_RST;
      endcase
    end
  end

  // Control strobes decoded from the current state and opcode.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_src   = 2'd0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    aluctl   = 4'd0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
        end
      end
      S_DECODE: begin
        aluctl = alu_c;
        if (is_j_c) begin
          pc_load = 1'b1;
          pc_src  = 2'd2;
        end
      end
      S_EXEC: begin
        aluctl = alu_c;
        alusrc = alusrc_c;
        regdst = is_add_c;
        if (is_beq_c) begin
          pc_load = zero;
          pc_src  = 2'd1;
        end else if (is_bne_c) begin
          pc_load = !zero;
          pc_src  = 2'd1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw_c;
        aluctl  = alu_c;
        alusrc  = alusrc_c;
        regdst  = is_add_c;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = is_lw_c;
        aluctl   = alu_c;
        alusrc   = alusrc_c;
        regdst   = is_add_c;
      end
      default: ;
    endcase
  end

endmodule
